regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 32×32 register file. It shares the file's single write port between two producers, the ALU/load path (req0) and a multi-cycle unit (req1), using valid/ready handshakes and round-robin priority. It drives the file's write enable, destination and data from registers. An optional scoreboard tracks outstanding destinations so that issue logic can detect read-after-write hazards on rs1/rs2.

## Interface
- XLEN, 32, data width of every write-back payload
- AW, 5, register address width (32 registers; x0 hardwired zero)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- req0_valid  in  1  producer 0 has a write pending
- req0_rd  in  AW  producer 0 destination
- req0_data  in  XLEN  producer 0 result
- req0_ready  out  1  producer 0 granted this cycle
- req1_valid / req1_rd / req1_data  in  1 / AW / XLEN  producer 1, same meaning
- req1_ready  out  1  producer 1 granted this cycle
- rf_we  out  1  register-file write enable (registered)
- rf_rd  out  AW  register-file write address (registered)
- rf_wdata  out  XLEN  register-file write data (registered)
- claim_valid  in  1  issue stage reserves a destination
- claim_rd  in  AW  destination being reserved
- rs1_addr, rs2_addr  in  AW  source addresses to check
- rs1_busy, rs2_busy  out  1  source has an outstanding write (combinational)
- last_grant  out  1  index of the most recent grant (priority pointer)

## Operation
- At most one grant per cycle. A transfer completes in a cycle where valid=1 and ready=1.
- ready is combinational from the valid inputs and the pointer. It never depends on data or rd.
- If only one requester is valid, that requester is granted.
- If both are valid, the requester ≠ last_grant is granted.
- last_grant updates to the granted index on every grant and holds when there is no grant. Its reset value is 1, so req0 wins the first contention.
- Producers hold valid, rd and data stable until they see ready. Dropping valid without a grant is illegal.
- Grant with rd≠0 sets rf_we=1, rf_rd=rd and rf_wdata=data on the next edge.
- Grant with rd=0 is accepted and consumed, but rf_we=0 on the next edge (the write is dropped).
- No grant: rf_we=0; rf_rd and rf_wdata hold their previous values.
- Scoreboard: a busy[31:1] vector; busy[0] is constant 0.
  - claim_valid with claim_rd≠0 sets busy[claim_rd].
  - rf_we=1 at an edge clears busy[rf_rd], the same edge on which the register file commits the write.
  - A claim and a clear of the same register at the same edge: set wins.
  - Claiming an already-busy register is an issue-stage protocol error. There is no count; the first write-back clears the bit.
- rsN_busy = busy[rsN_addr]. rsN_addr=0 always gives 0.

## Timing
- Reset values: rf_we=0, rf_rd=0, rf_wdata=0, last_grant=1, busy=0, req0_ready=req1_ready=0. Reset takes effect asynchronously, mid-transfer included, and any pending grant is lost.
- Latency: grant in cycle N gives rf_we in cycle N+1. The register file holds the value from the N+2 edge, and busy clears at that same edge.
- Throughput: one write per cycle, sustained. Under continuous contention grants alternate 0,1,0,1…
- Outputs rf_* are flop outputs only. ready and busy are combinational.

## Configuration
- WB_SCOREBOARD_EN defined: busy vector, claim logic and the rsN_busy outputs are implemented as above.
- WB_SCOREBOARD_EN undefined: no busy flops; rs1_busy=rs2_busy=0 constantly; claim_valid and claim_rd are ignored. Arbitration and write-back behaviour are unchanged.

## Test plan
- Reset, then req0 only, rd=5, data=0xDEADBEEF: req0_ready=1 that cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF; following cycle rf_we=0.
- Both valid for 4 cycles from reset (rd=1/2): grants 0,1,0,1; rf_rd sequence 1,2,1,2; last_grant ends at 1.
- req1 only, rd=0, data=0x1234: req1_ready=1; next cycle rf_we=0 and rf_wdata unchanged.
- With scoreboard enabled: claim rd=7; rs1_addr=7 gives rs1_busy=1 and rs2_addr=0 gives rs2_busy=0. Write-back to 7 is granted in cycle N; rs1_busy stays 1 through N+1 and reads 0 in N+2. A claim of 7 at the same edge as the clear leaves busy=1.
- reset driven low mid-stream while rf_we=1: rf_we, busy and last_grant return to their reset values immediately, before the next clk edge.
- Macro undefined: claim rd=3 with rs1_addr=3 gives rs1_busy=0; arbitration results are identical to the second scenario.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two result producers, the arbiter and the register-file write port.
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            req0_valid;
    logic [AW-1:0]   req0_rd;
    logic [XLEN-1:0] req0_data;
    logic            req0_ready;
    logic            req1_valid;
    logic [AW-1:0]   req1_rd;
    logic [XLEN-1:0] req1_data;
    logic            req1_ready;
    logic            rf_we;
    logic [AW-1:0]   rf_rd;
    logic [XLEN-1:0] rf_wdata;

    modport master (
        output req0_valid, req0_rd, req0_data,
        output req1_valid, req1_rd, req1_data,
        input  req0_ready, req1_ready,
        input  rf_we, rf_rd, rf_wdata
    );

    modport slave (
        input  req0_valid, req0_rd, req0_data,
        input  req1_valid, req1_rd, req1_data,
        output req0_ready, req1_ready,
        output rf_we, rf_rd, rf_wdata
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the 32x32 register file, with an optional
// RAW-hazard scoreboard enabled by defining WB_SCOREBOARD_EN.
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus,
    input  logic                 claim_valid,
    input  logic [AW-1:0]        claim_rd,
    input  logic [AW-1:0]        rs1_addr,
    input  logic [AW-1:0]        rs2_addr,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 last_grant
);
    localparam int NREG = 1 << AW;

    logic            gnt0;
    logic            gnt1;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            last_grant_reg;
    logic            rf_we_reg;
    logic [AW-1:0]   rf_rd_reg;
    logic [XLEN-1:0] rf_wdata_reg;

    // Ready is gated by reset so nothing is granted while the block is held in reset.
    always_comb begin
        gnt0     = reset && bus.req0_valid && (!bus.req1_valid || last_grant_reg);
        gnt1     = reset && bus.req1_valid && (!bus.req0_valid || !last_grant_reg);
        sel_rd   = gnt1 ? bus.req1_rd   : bus.req0_rd;
        sel_data = gnt1 ? bus.req1_data : bus.req0_data;
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    // Writes to x0 are consumed but leave the write port idle and its address/data untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_reg <= 1'b1;
            rf_we_reg      <= 1'b0;
            rf_rd_reg      <= '0;
            rf_wdata_reg   <= '0;
        end else begin
            rf_we_reg <= 1'b0;
            if (gnt0 || gnt1) begin
                last_grant_reg <= gnt1;
                if (sel_rd != '0) begin
                    rf_we_reg    <= 1'b1;
                    rf_rd_reg    <= sel_rd;
                    rf_wdata_reg <= sel_data;
                end
            end
        end
    end

    assign bus.rf_we    = rf_we_reg;
    assign bus.rf_rd    = rf_rd_reg;
    assign bus.rf_wdata = rf_wdata_reg;
    assign last_grant   = last_grant_reg;

`ifdef WB_SCOREBOARD_EN
    wire [NREG-1:0] busy_vec;
    assign busy_vec[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_busy
            logic busy_reg;
            // A claim landing on the same edge as the committing write keeps the bit set.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    busy_reg <= 1'b0;
                end else if (claim_valid && (claim_rd == AW'(gi))) begin
                    busy_reg <= 1'b1;
                end else if (rf_we_reg && (rf_rd_reg == AW'(gi))) begin
                    busy_reg <= 1'b0;
                end
            end
            assign busy_vec[gi] = busy_reg;
        end
    endgenerate

    assign rs1_busy = busy_vec[rs1_addr];
    assign rs2_busy = busy_vec[rs2_addr];
`else
    logic unused_scoreboard_inputs;
    assign unused_scoreboard_inputs = ^{claim_valid, claim_rd, rs1_addr, rs2_addr, NREG[0]};
    assign rs1_busy = 1'b0;
    assign rs2_busy = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; scoreboard scenarios run when
// WB_SCOREBOARD_EN is defined, the macro-off checks otherwise.
module tb_regfile_wb_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       claim_valid;
    logic [4:0] claim_rd;
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    logic       rs1_busy;
    logic       rs2_busy;
    logic       last_grant;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.XLEN(32), .AW(5)) bus ();

    regfile_wb_arbiter #(.XLEN(32), .AW(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .claim_valid (claim_valid),
        .claim_rd    (claim_rd),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .last_grant  (last_grant)
    );

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_rd = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_rd = '0; bus.req1_data = '0;
        claim_valid = 1'b0; claim_rd = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd4; bus.req0_data = 32'h1111_2222;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we: got %b want 0", bus.rf_we); end
        n_cmp++; if (bus.rf_rd !== 5'd0) begin n_err++; $display("FAIL reset_rf_rd: got %0d want 0", bus.rf_rd); end
        n_cmp++; if (bus.rf_wdata !== 32'h0) begin n_err++; $display("FAIL reset_rf_wdata: got %h want 0", bus.rf_wdata); end
        n_cmp++; if (last_grant !== 1'b1) begin n_err++; $display("FAIL reset_last_grant: got %b want 1", last_grant); end
        n_cmp++; if (bus.req0_ready !== 1'b0) begin n_err++; $display("FAIL reset_req0_ready: got %b want 0", bus.req0_ready); end
        $display("reset: rf_we=%b rf_rd=%0d last_grant=%b", bus.rf_we, bus.rf_rd, last_grant);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
    endtask

    task automatic test_single();
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd5; bus.req0_data = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL single_ready0: got %b want 1", bus.req0_ready); end
        n_cmp++; if (bus.req1_ready !== 1'b0) begin n_err++; $display("FAIL single_ready1: got %b want 0", bus.req1_ready); end
        @(posedge clk); #1;
        n_cmp++; if (bus.rf_we !== 1'b1) begin n_err++; $display("FAIL single_we: got %b want 1", bus.rf_we); end
        n_cmp++; if (bus.rf_rd !== 5'd5) begin n_err++; $display("FAIL single_rd: got %0d want 5", bus.rf_rd); end
        n_cmp++; if (bus.rf_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_wdata: got %h want deadbeef", bus.rf_wdata); end
        n_cmp++; if (last_grant !== 1'b0) begin n_err++; $display("FAIL single_last_grant: got %b want 0", last_grant); end
        $display("single: rd=%0d data=%h we=%b", bus.rf_rd, bus.rf_wdata, bus.rf_we);
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL single_we_after: got %b want 0", bus.rf_we); end
        n_cmp++; if (bus.rf_rd !== 5'd5) begin n_err++; $display("FAIL single_rd_hold: got %0d want 5", bus.rf_rd); end
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic       exp_g1;
        logic [4:0] exp_rd;
        logic [31:0] exp_data;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd1; bus.req0_data = 32'hA0A0_0001;
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd2; bus.req1_data = 32'hB0B0_0002;
        for (int i = 0; i < 4; i++) begin
            exp_g1   = (i == 1) || (i == 3);
            exp_rd   = exp_g1 ? 5'd2 : 5'd1;
            exp_data = exp_g1 ? 32'hB0B0_0002 : 32'hA0A0_0001;
            #1;
            n_cmp++; if (bus.req1_ready !== exp_g1 || bus.req0_ready !== !exp_g1) begin
                n_err++; $display("FAIL contend_grant[%0d]: got r0=%b r1=%b want r1=%b", i, bus.req0_ready, bus.req1_ready, exp_g1);
            end
            @(posedge clk); #1;
            n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== exp_rd || bus.rf_wdata !== exp_data) begin
                n_err++; $display("FAIL contend_write[%0d]: got we=%b rd=%0d data=%h want we=1 rd=%0d data=%h", i, bus.rf_we, bus.rf_rd, bus.rf_wdata, exp_rd, exp_data);
            end
            $display("contend[%0d]: grant=%0d rf_rd=%0d", i, last_grant, bus.rf_rd);
            @(negedge clk);
        end
        idle_inputs();
        n_cmp++; if (last_grant !== 1'b1) begin n_err++; $display("FAIL contend_last_grant: got %b want 1", last_grant); end
    endtask

    task automatic test_rd_zero();
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd3; bus.req0_data = 32'hC0C0_0003;
        @(posedge clk); #1;
        n_cmp++; if (last_grant !== 1'b0) begin n_err++; $display("FAIL rdzero_pre_grant: got %b want 0", last_grant); end
        @(negedge clk);
        idle_inputs();
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd0; bus.req1_data = 32'h0000_1234;
        #1;
        n_cmp++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
            n_err++; $display("FAIL rdzero_ready: got r0=%b r1=%b want r0=0 r1=1", bus.req0_ready, bus.req1_ready);
        end
        @(posedge clk); #1;
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL rdzero_we: got %b want 0", bus.rf_we); end
        n_cmp++; if (bus.rf_wdata !== 32'hC0C0_0003) begin n_err++; $display("FAIL rdzero_wdata: got %h want c0c00003", bus.rf_wdata); end
        n_cmp++; if (bus.rf_rd !== 5'd3) begin n_err++; $display("FAIL rdzero_rd: got %0d want 3", bus.rf_rd); end
        n_cmp++; if (last_grant !== 1'b1) begin n_err++; $display("FAIL rdzero_last_grant: got %b want 1", last_grant); end
        $display("rd_zero: we=%b wdata=%h", bus.rf_we, bus.rf_wdata);
        @(negedge clk);
        idle_inputs();
    endtask

`ifdef WB_SCOREBOARD_EN
    task automatic test_scoreboard();
        claim_valid = 1'b1; claim_rd = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd0;
        @(posedge clk); #1;
        n_cmp++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL sb_claim_rs1: got %b want 1", rs1_busy); end
        n_cmp++; if (rs2_busy !== 1'b0) begin n_err++; $display("FAIL sb_x0_rs2: got %b want 0", rs2_busy); end
        @(negedge clk);
        claim_valid = 1'b0; rs2_addr = 5'd7;
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd7; bus.req0_data = 32'h7777_0007;
        #1;
        n_cmp++; if (rs2_busy !== 1'b1) begin n_err++; $display("FAIL sb_rs2_busy: got %b want 1", rs2_busy); end
        n_cmp++; if (bus.req0_ready !== 1'b1 || rs1_busy !== 1'b1) begin
            n_err++; $display("FAIL sb_cycle_n: got ready=%b busy=%b want 1 1", bus.req0_ready, rs1_busy);
        end
        @(posedge clk); #1;
        n_cmp++; if (bus.rf_we !== 1'b1 || rs1_busy !== 1'b1) begin
            n_err++; $display("FAIL sb_cycle_n1: got we=%b busy=%b want 1 1", bus.rf_we, rs1_busy);
        end
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        n_cmp++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL sb_cycle_n2: got %b want 0", rs1_busy); end
        $display("scoreboard: write to x7 cleared busy=%b", rs1_busy);
        @(negedge clk);
        claim_valid = 1'b1; claim_rd = 5'd7;
        @(negedge clk);
        claim_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd7; bus.req0_data = 32'h7777_0008;
        @(negedge clk);
        idle_inputs();
        claim_valid = 1'b1; claim_rd = 5'd7;
        @(posedge clk); #1;
        n_cmp++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL sb_set_wins: got %b want 1", rs1_busy); end
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        n_cmp++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL sb_set_holds: got %b want 1", rs1_busy); end
        $display("scoreboard: same-edge claim and clear busy=%b", rs1_busy);
        @(negedge clk);
    endtask
`else
    task automatic test_no_scoreboard();
        claim_valid = 1'b1; claim_rd = 5'd3; rs1_addr = 5'd3; rs2_addr = 5'd3;
        @(posedge clk); #1;
        n_cmp++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL nosb_rs1: got %b want 0", rs1_busy); end
        n_cmp++; if (rs2_busy !== 1'b0) begin n_err++; $display("FAIL nosb_rs2: got %b want 0", rs2_busy); end
        $display("no_scoreboard: claim x3 rs1_busy=%b", rs1_busy);
        @(negedge clk);
        idle_inputs();
    endtask
`endif

    task automatic test_reset_async();
        rs1_addr = 5'd7;
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd9; bus.req0_data = 32'h9999_0009;
        @(posedge clk); #1;
        n_cmp++; if (bus.rf_we !== 1'b1 || last_grant !== 1'b0) begin
            n_err++; $display("FAIL areset_pre: got we=%b lg=%b want 1 0", bus.rf_we, last_grant);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL areset_we: got %b want 0", bus.rf_we); end
        n_cmp++; if (bus.rf_rd !== 5'd0 || bus.rf_wdata !== 32'h0) begin
            n_err++; $display("FAIL areset_rd_data: got rd=%0d data=%h want 0 0", bus.rf_rd, bus.rf_wdata);
        end
        n_cmp++; if (last_grant !== 1'b1) begin n_err++; $display("FAIL areset_last_grant: got %b want 1", last_grant); end
        n_cmp++; if (bus.req0_ready !== 1'b0) begin n_err++; $display("FAIL areset_ready: got %b want 0", bus.req0_ready); end
        n_cmp++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL areset_busy: got %b want 0", rs1_busy); end
        $display("async_reset: we=%b last_grant=%b busy=%b", bus.rf_we, last_grant, rs1_busy);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_rd_zero();
`ifdef WB_SCOREBOARD_EN
        test_scoreboard();
`else
        test_no_scoreboard();
`endif
        test_reset_async();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
